// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Central stall/flush sequencer for the 5-stage MIPS32 pipeline. Arbitrates
//   memory freezes, taken branches, hazard stalls and ID-stage jumps into the
//   pipeline-register write enables and flushes. Remembers a branch that
//   resolves while memory is busy and applies it when the access completes.
//   Keeps saturating stall/flush counters and traps runaway hazard stalls.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   hazard_detected   : load-use / branch-operand hazard for the ID instruction
//   branch_taken      : EXE-stage branch resolved taken
//   jump_id           : jump decoded in ID
//   dmem_req          : MEM stage has a data access in flight
//   dmem_ready        : data memory completes the access this cycle
//   pc_write          : PC load enable
//   if_id_write       : IF/ID enable
//   if_id_flush       : clear IF/ID to NOP
//   id_ex_flush       : clear ID/EX to a bubble
//   pipe_adv          : enable for ID/EX, EX/MEM, MEM/WB
//   stall_timeout     : sticky trap flag (cleared only by reset)
//   stall_cycles      : saturating count of cycles with pc_write = 0
//   flush_events      : saturating count of applied branch flushes
//
// Memory handshake: an access is outstanding while dmem_req = 1; the cycle in
// which dmem_ready = 1 completes it. dmem_req & ~dmem_ready freezes the whole
// pipeline; dmem_req & dmem_ready in one cycle is a zero-wait access.

module pipeline_stall_ctrl #(
    parameter int MAX_STALL = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             jump_id,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_adv,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int RUN_W = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_STALL    = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_TRAP     = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             br_pend;
    logic             br_pend_nxt;
    logic [RUN_W-1:0] stall_run;
    logic [RUN_W-1:0] stall_run_nxt;
    logic             timeout_nxt;
    logic             flush_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_RUN;
            br_pend       <= 1'b0;
            stall_run     <= '0;
            stall_timeout <= 1'b0;
            stall_cycles  <= '0;
            flush_events  <= '0;
        end else begin
            state         <= state_nxt;
            br_pend       <= br_pend_nxt;
            stall_run     <= stall_run_nxt;
            stall_timeout <= timeout_nxt;
            if (!pc_write && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (flush_inc && flush_events != '1) begin
                flush_events <= flush_events + 1'b1;
            end
        end
    end

    // Rules are evaluated in strict priority order. MEM_WAIT and STALL carry no
    // exit condition of their own: every non-trap cycle re-runs the priority
    // chain, so a pending branch is applied in the very cycle dmem_ready rises.
    always_comb begin
        state_nxt     = state;
        br_pend_nxt   = br_pend;
        stall_run_nxt = stall_run;
        timeout_nxt   = stall_timeout;
        flush_inc     = 1'b0;
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        pipe_adv      = 1'b0;

        if (state == S_TRAP) begin
            state_nxt = S_TRAP;
        end else if (dmem_req && !dmem_ready) begin
            state_nxt = S_MEM_WAIT;
            if (branch_taken) begin
                br_pend_nxt = 1'b1;
            end
        end else if (branch_taken || br_pend) begin
            // The branch squashes whatever sits in IF/ID and ID/EX, including
            // an instruction the hazard unit wanted to stall.
            pc_write      = 1'b1;
            if_id_write   = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            pipe_adv      = 1'b1;
            br_pend_nxt   = 1'b0;
            flush_inc     = 1'b1;
            stall_run_nxt = '0;
            state_nxt     = S_RUN;
        end else if (hazard_detected) begin
            id_ex_flush = 1'b1;
            pipe_adv    = 1'b1;
            if (stall_run == RUN_W'(MAX_STALL - 1)) begin
                stall_run_nxt = RUN_W'(MAX_STALL);
                timeout_nxt   = 1'b1;
                state_nxt     = S_TRAP;
            end else begin
                stall_run_nxt = stall_run + RUN_W'(1);
                state_nxt     = S_STALL;
            end
        end else if (jump_id) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            pipe_adv    = 1'b1;
            state_nxt   = S_RUN;
        end else begin
            pc_write      = 1'b1;
            if_id_write   = 1'b1;
            pipe_adv      = 1'b1;
            stall_run_nxt = '0;
            state_nxt     = S_RUN;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl
//   Drives two instances (default parameters, and MAX_STALL=32 / CNT_W=4) with
//   the same inputs. A driver pushes the expected outputs of each cycle into a
//   queue; a monitor on the falling edge pops and compares.

module tb_pipeline_stall_ctrl;

    localparam int W = 76;  // two instances x {en[4:0], timeout, sc[15:0], fe[15:0]}

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic hazard_detected, branch_taken, jump_id, dmem_req, dmem_ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUTs ----------------
    logic        pc_write0, if_id_write0, if_id_flush0, id_ex_flush0, pipe_adv0, timeout0;
    logic [15:0] sc0, fe0;
    logic        pc_write1, if_id_write1, if_id_flush1, id_ex_flush1, pipe_adv1, timeout1;
    logic [3:0]  sc1, fe1;

    pipeline_stall_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .jump_id(jump_id), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write0), .if_id_write(if_id_write0), .if_id_flush(if_id_flush0),
        .id_ex_flush(id_ex_flush0), .pipe_adv(pipe_adv0), .stall_timeout(timeout0),
        .stall_cycles(sc0), .flush_events(fe0)
    );

    pipeline_stall_ctrl #(.MAX_STALL(32), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .jump_id(jump_id), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write1), .if_id_write(if_id_write1), .if_id_flush(if_id_flush1),
        .id_ex_flush(id_ex_flush1), .pipe_adv(pipe_adv1), .stall_timeout(timeout1),
        .stall_cycles(sc1), .flush_events(fe1)
    );

    // ---------------- reference model ----------------
    // Enable vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_adv}
    int max_stall[2] = '{8, 32};
    int cnt_max[2]   = '{65535, 15};
    bit m_trap[2];
    bit m_pend[2];
    int m_run[2];
    int m_sc[2];
    int m_fe[2];

    function automatic int sat_inc(input int v, input int lim);
        return (v >= lim) ? lim : v + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_trap[i] = 1'b0;
            m_pend[i] = 1'b0;
            m_run[i]  = 0;
            m_sc[i]   = 0;
            m_fe[i]   = 0;
        end
    endtask

    task automatic model_step(input int i, input bit h, input bit b, input bit j,
                              input bit rq, input bit rd, output logic [4:0] en);
        if (m_trap[i]) begin
            en = 5'b00000;
        end else if (rq && !rd) begin
            en = 5'b00000;
            if (b) m_pend[i] = 1'b1;
        end else if (b || m_pend[i]) begin
            en        = 5'b11111;
            m_pend[i] = 1'b0;
            m_fe[i]   = sat_inc(m_fe[i], cnt_max[i]);
            m_run[i]  = 0;
        end else if (h) begin
            en       = 5'b00011;
            m_run[i] = m_run[i] + 1;
            if (m_run[i] >= max_stall[i]) m_trap[i] = 1'b1;
        end else if (j) begin
            en = 5'b11101;
        end else begin
            en       = 5'b11001;
            m_run[i] = 0;
        end
        if (en[4] == 1'b0) m_sc[i] = sat_inc(m_sc[i], cnt_max[i]);
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic push_expect(input bit h, input bit b, input bit j, input bit rq,
                               input bit rd, input bit in_reset);
        logic [W-1:0] e;
        logic [37:0]  part;
        logic [4:0]   en;
        for (int i = 0; i < 2; i++) begin
            part[32]    = m_trap[i];
            part[31:16] = 16'(m_sc[i]);
            part[15:0]  = 16'(m_fe[i]);
            if (in_reset) en = 5'b11001;
            else model_step(i, h, b, j, rq, rd, en);
            part[37:33] = en;
            if (i == 0) e[75:38] = part;
            else        e[37:0]  = part;
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit h, input bit b, input bit j, input bit rq, input bit rd);
        @(posedge clk);
        #2;
        rst_n           = 1'b1;
        hazard_detected = h;
        branch_taken    = b;
        jump_id         = j;
        dmem_req        = rq;
        dmem_ready      = rd;
        push_expect(h, b, j, rq, rd, 1'b0);
    endtask

    // Reset asserted mid-cycle with all inputs low; released at the start of
    // the next driven cycle.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n           = 1'b0;
        hazard_detected = 1'b0;
        branch_taken    = 1'b0;
        jump_id         = 1'b0;
        dmem_req        = 1'b0;
        dmem_ready      = 1'b0;
        model_reset();
        push_expect(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("enables0", 16'({pc_write0, if_id_write0, if_id_flush0, id_ex_flush0, pipe_adv0}), 16'(e[75:71]));
            check("timeout0", 16'(timeout0), 16'(e[70]));
            check("stall_cycles0", sc0, e[69:54]);
            check("flush_events0", fe0, e[53:38]);
            check("enables1", 16'({pc_write1, if_id_write1, if_id_flush1, id_ex_flush1, pipe_adv1}), 16'(e[37:33]));
            check("timeout1", 16'(timeout1), 16'(e[32]));
            check("stall_cycles1", 16'(sc1), e[31:16]);
            check("flush_events1", 16'(fe1), e[15:0]);
        end
    end

    // ---------------- stimulus ----------------
    bit r_h, r_b, r_j, r_rq, r_rd;

    initial begin
        rst_n           = 1'b0;
        hazard_detected = 1'b0;
        branch_taken    = 1'b0;
        jump_id         = 1'b0;
        dmem_req        = 1'b0;
        dmem_ready      = 1'b0;
        model_reset();

        do_reset();
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // load-use: one stall cycle then resume
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // reset in the middle of a stall
        cycle(1, 0, 0, 0, 0);
        do_reset();
        cycle(0, 0, 0, 0, 0);

        // branch arriving during a 3-cycle memory wait
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0);

        // branch overrides hazard
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // hazard wins over jump, jump retried afterwards
        cycle(1, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);

        // zero-wait access together with a branch on the ready cycle
        cycle(0, 1, 0, 1, 1);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 1, 1);
        cycle(0, 0, 0, 0, 0);

        // reset mid-wait discards the pending branch
        cycle(0, 1, 0, 1, 0);
        do_reset();
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0);

        // runaway stall: trap after MAX_STALL hazard cycles, sticky until reset
        do_reset();
        for (int n = 0; n < 10; n++) cycle(1, 0, 0, 0, 0);
        for (int n = 0; n < 3; n++)  cycle(0, 1, 1, 0, 0);
        do_reset();
        cycle(0, 0, 0, 0, 0);

        // counter saturation on the narrow instance
        do_reset();
        for (int n = 0; n < 20; n++) cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                r_h  = ($urandom_range(0, 99) < 25);
                r_b  = ($urandom_range(0, 99) < 15);
                r_j  = ($urandom_range(0, 99) < 15);
                r_rq = ($urandom_range(0, 99) < 35);
                r_rd = ($urandom_range(0, 99) < 50);
                cycle(r_h, r_b, r_j, r_rq, r_rd);
            end
        end

        // drain the scoreboard within a bounded number of cycles
        for (int n = 0; n < 5 && exp_q.size() > 0; n++) @(negedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage MIPS32 pipeline. It takes the hazard unit's `hazard_detected`, the EXE-stage branch resolution, ID-stage jumps and the data-memory ready handshake, and drives every pipeline-register write enable and flush. It remembers branches that resolve during a memory wait and applies them once the wait ends. It also keeps stall/flush performance counters and traps runaway stalls.

## Interface
Parameters:
- `MAX_STALL`, default 8: largest number of consecutive hazard-stall cycles allowed before the block traps.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `hazard_detected` in 1: load-use or branch-operand hazard signalled by the hazard unit for the instruction in ID.
- `branch_taken` in 1: branch resolved as taken in EXE.
- `jump_id` in 1: jump decoded in ID.
- `dmem_req` in 1: MEM stage has a data-memory access in flight.
- `dmem_ready` in 1: data memory has completed the access this cycle.
- `pc_write` out 1: PC load enable.
- `if_id_write` out 1: IF/ID register enable.
- `if_id_flush` out 1: clear IF/ID to NOP.
- `id_ex_flush` out 1: clear ID/EX to a bubble.
- `pipe_adv` out 1: enable for ID/EX, EX/MEM and MEM/WB.
- `stall_timeout` out 1: sticky trap flag.
- `stall_cycles` out CNT_W: saturating count of cycles with `pc_write`=0.
- `flush_events` out CNT_W: saturating count of applied branch flushes.

## Operation
States: RUN, STALL, MEM_WAIT, TRAP. State is registered. Outputs are combinational from the current state, inputs and `br_pend`.

Each cycle, outside TRAP, the first matching rule applies:
1. **freeze** (`dmem_req & ~dmem_ready`)
   - All enables 0, no flush.
   - Next state MEM_WAIT.
   - If `branch_taken` is 1 this cycle, set `br_pend`=1.
2. **branch** (`branch_taken | br_pend`)
   - `pc_write`=1, `if_id_write`=1, `if_id_flush`=1, `id_ex_flush`=1, `pipe_adv`=1.
   - Clear `br_pend`. `flush_events` +1.
   - Next state RUN; clear `stall_run`.
   - The branch overrides any hazard, because the stalled instruction is squashed.
3. **hazard** (`hazard_detected`)
   - `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1, `pipe_adv`=1.
   - Next state STALL; `stall_run` +1.
4. **jump** (`jump_id`)
   - All enables 1, `if_id_flush`=1.
   - Next state RUN.
5. **default**
   - All enables 1, no flush.
   - Next state RUN; clear `stall_run`.

Additional rules:
- **Trap entry:** when a hazard cycle would take `stall_run` to MAX_STALL, the next state is TRAP and `stall_timeout` is set.
- **TRAP:** all enables 0, no flush. Exit only by reset.
- **MEM_WAIT:** there is no separate exit condition. The cycle in which `dmem_ready`=1 re-evaluates rules 2–5, so a pending branch is applied in that same cycle.
- **`stall_cycles`:** +1 on every cycle with `pc_write`=0, TRAP cycles included.
- **Counters:** both saturate at all-ones and never wrap.
- **`stall_run`:** ceil(log2(MAX_STALL+1)) bits.

## Timing
- **Reset** (`rst_n` low, asynchronous, takes effect immediately):
  - State RUN; `br_pend`, `stall_run`, both counters and `stall_timeout` cleared to 0.
  - With all inputs 0 during reset, outputs are `pc_write`=1, `if_id_write`=1, `pipe_adv`=1, both flushes 0.
- **Reset mid-wait:** discards `br_pend`.
- **Latency:**
  - Enables and flushes respond combinationally in the same cycle as their inputs.
  - Counters, `stall_timeout` and state update on the next rising edge.
- **`dmem_req` with `dmem_ready` in the same cycle:** not a freeze; zero wait.
- **`branch_taken` on the `dmem_ready` cycle:** applied in that cycle. `br_pend` is already clear, or is cleared, so there is exactly one flush and `flush_events` increments by 1.
- **`jump_id` with `hazard_detected`:** the hazard wins. The jump is retried when the stall releases.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stall → outputs immediately 1/1/0/0/1; counters 0; `stall_timeout`=0.
- **Load-use:** `hazard_detected`=1 for 1 cycle → `pc_write`=0, `id_ex_flush`=1 in that cycle; next cycle all enables 1; `stall_cycles`=1.
- **Branch during a memory wait:** `dmem_req`=1, `dmem_ready`=0 for 3 cycles, `branch_taken`=1 in cycle 2 → all enables 0 for 3 cycles. On the `dmem_ready` cycle, both flushes are 1 and `pc_write`=1; `flush_events`=1; `stall_cycles`=3.
- **Branch overrides hazard:** `branch_taken`=1 and `hazard_detected`=1 together → `pc_write`=1, both flushes 1; next state RUN.
- **Runaway stall:** `hazard_detected` held high with MAX_STALL=8 → after 8 stall cycles, `stall_timeout`=1 and TRAP; enables stay 0 after `hazard_detected` drops; cleared only by `rst_n`.
- **Counter saturation:** CNT_W=4, stall for 20 cycles with MAX_STALL=32 → `stall_cycles` holds at 15.
